// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction-fetch front end.
package otter_fetch_pkg;

  localparam logic [31:0] OTTER_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  typedef enum logic {
    RUN_IDLE   = 1'b0,
    RUN_ACTIVE = 1'b1
  } run_state_e;

endpackage

// File: rtl/otter_fetch_buffer_if.sv
// Memory-port and decode-handshake bundle of the fetch buffer.
interface otter_fetch_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 14
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              IMEM_RDEN;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic [31:0]       IMEM_DATA;
  logic              REDIRECT;
  logic [31:0]       REDIRECT_PC;
  logic              DE_READY;
  logic              DE_VALID;
  logic [31:0]       DE_IR;
  logic [31:0]       DE_PC;
  logic [CNT_W-1:0]  COUNT;

  // Fetch-buffer side.
  modport master (
    output IMEM_RDEN, IMEM_ADDR, DE_VALID, DE_IR, DE_PC, COUNT,
    input  IMEM_DATA, REDIRECT, REDIRECT_PC, DE_READY
  );

  // Memory / PC-source / decode side.
  modport slave (
    input  IMEM_RDEN, IMEM_ADDR, DE_VALID, DE_IR, DE_PC, COUNT,
    output IMEM_DATA, REDIRECT, REDIRECT_PC, DE_READY
  );

endinterface

// File: rtl/otter_fetch_fifo.sv
// DEPTH-entry ring of {pc, ir} entries; flush wins over push and pop.
module otter_fetch_fifo
  import otter_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
      else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/otter_fetch_buffer.sv
// OTTER prefetch queue with credit-based issue and redirect flush.
// Optional OTTER_FETCH_STATS_EN adds STAT_BUBBLES / STAT_FLUSHES counters.
module otter_fetch_buffer
  import otter_fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  otter_fetch_buffer_if.master  bus
`ifdef OTTER_FETCH_STATS_EN
  ,
  output logic [31:0]           STAT_BUBBLES,
  output logic [31:0]           STAT_FLUSHES
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  run_state_e   run_q, run_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;

  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             run, de_valid, pop, push, issue;
  logic [31:0]      redirect_pc, issue_pc;
  logic [OCC_W-1:0] occ_after;

  assign run         = (run_q == RUN_ACTIVE);
  assign redirect_pc = bus.REDIRECT_PC & ~32'h0000_0003;
  assign de_valid    = (count != '0);
  assign pop         = de_valid & bus.DE_READY & ~bus.REDIRECT;
  assign push        = pend_q & ~bus.REDIRECT;
  assign issue_pc    = bus.REDIRECT ? redirect_pc : fetch_pc_q;

  // Credit check: a slot is reserved for every request still in flight.
  assign occ_after = OCC_W'(count) + OCC_W'(pend_q) - OCC_W'(pop);
  assign issue     = run & (bus.REDIRECT | (occ_after < OCC_W'(DEPTH)));

  assign push_entry = '{pc: pend_pc_q, ir: bus.IMEM_DATA};

  otter_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (bus.REDIRECT),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    run_d      = run_q;
    fetch_pc_d = fetch_pc_q;
    pend_d     = 1'b0;
    pend_pc_d  = pend_pc_q;
    case (run_q)
      RUN_IDLE:   run_d = RUN_ACTIVE;
      RUN_ACTIVE: run_d = RUN_ACTIVE;
      default:    run_d = RUN_IDLE;
    endcase
    if (issue) begin
      fetch_pc_d = issue_pc + 32'd4;
      pend_d     = 1'b1;
      pend_pc_d  = issue_pc;
    end else if (bus.REDIRECT) begin
      fetch_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q      <= RUN_IDLE;
      fetch_pc_q <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      run_q      <= run_d;
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign bus.IMEM_RDEN = issue;
  assign bus.IMEM_ADDR = issue_pc[ADDR_W+1:2];
  assign bus.DE_VALID  = de_valid;
  assign bus.DE_IR     = de_valid ? head.ir : OTTER_NOP;
  assign bus.DE_PC     = de_valid ? head.pc : 32'h0000_0000;
  assign bus.COUNT     = count;

`ifdef OTTER_FETCH_STATS_EN
  logic [31:0] bubbles_q, flushes_q;

  // Saturating event counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bubbles_q <= '0;
      flushes_q <= '0;
    end else begin
      if (run && bus.DE_READY && !de_valid && (bubbles_q != 32'hFFFF_FFFF))
        bubbles_q <= bubbles_q + 32'd1;
      if (bus.REDIRECT && (flushes_q != 32'hFFFF_FFFF))
        flushes_q <= flushes_q + 32'd1;
    end
  end

  assign STAT_BUBBLES = bubbles_q;
  assign STAT_FLUSHES = flushes_q;
`endif

endmodule
